// File: rtl/jk_bank_ctrl_if.sv
// Command channel of the JK bank controller: valid/ready handshake plus the
// operation, load value and serial input that are sampled on acceptance.
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_in;

    modport master (
        output cmd_valid, cmd_op, cmd_data, ser_in,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, ser_in,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer for a bank of external JK flip-flops: accepts a register command,
// drives J/K for one cycle toward the computed target, checks the bank state
// read back on q_in, retries a bounded number of times and reports the result.
module jk_bank_ctrl #(
    parameter int WIDTH      = 4,
    parameter int USE_TOGGLE = 0,
    parameter int MAX_RETRY  = 1
) (
    input  logic             clk,
    input  logic             clear,
    jk_bank_ctrl_if.slave    cmd,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cout
);
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_SET  = 3'b111;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
    } jk_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] exp_q;
    logic [2:0]       retry_cnt;
    logic [WIDTH-1:0] tgt;
    logic             tgt_cout;
    logic             accept;
    logic             match;
    logic             retry_ok;

    // Per-bit J/K needed to move the bank from c to t; bits already at target hold.
    function automatic jk_t jk_drive(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] c);
        jk_t r;
        if (USE_TOGGLE != 0) begin
            r.j = t ^ c;
            r.k = t ^ c;
        end else begin
            r.j = t & ~c;
            r.k = ~t & c;
        end
        return r;
    endfunction

    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    assign match    = (q_in == exp_q);
    assign retry_ok = (retry_cnt < 3'(MAX_RETRY));

    // Target value and carry-out of the offered command, from the live bank state.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        tgt      = q_in;
        tgt_cout = 1'b0;
        case (cmd.cmd_op)
            OP_LOAD: tgt = cmd.cmd_data;
            OP_INC: begin
                tgt      = q_in + WIDTH'(1);
                tgt_cout = &q_in;
            end
            OP_DEC: begin
                tgt      = q_in - WIDTH'(1);
                tgt_cout = ~|q_in;
            end
            OP_SHL: begin
                tgt      = {q_in[WIDTH-2:0], cmd.ser_in};
                tgt_cout = q_in[WIDTH-1];
            end
            OP_SHR: begin
                tgt      = {cmd.ser_in, q_in[WIDTH-1:1]};
                tgt_cout = q_in[0];
            end
            OP_CLR:  tgt = '0;
            OP_SET:  tgt = '1;
            default: tgt = q_in;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: one DRIVE/CHECK pair per attempt, retries loop back to DRIVE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DRIVE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = (match || !retry_ok) ? DONE : DRIVE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs; ready is also gated by clear so nothing is accepted in reset.
    always_comb begin
        cmd.cmd_ready = (state == IDLE) && !clear;
        busy          = (state != IDLE);
        done          = (state == DONE);
    end

    // Datapath: target capture, J/K pulse generation, retry counting and status.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            exp_q     <= '0;
            j_out     <= '0;
            k_out     <= '0;
            retry_cnt <= '0;
            err       <= 1'b0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        exp_q          <= tgt;
                        cout           <= tgt_cout;
                        err            <= 1'b0;
                        {j_out, k_out} <= jk_drive(tgt, q_in);
                    end
                end
                DRIVE: begin
                    j_out <= '0;
                    k_out <= '0;
                end
                CHECK: begin
                    if (!match) begin
                        if (retry_ok) begin
                            {j_out, k_out} <= jk_drive(exp_q, q_in);
                            retry_cnt      <= retry_cnt + 3'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DONE:    retry_cnt <= '0;
                default: retry_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench: two controllers (set/reset and toggle style) each drive a
// modelled JK bank with optional stuck-at faults on its read-back path. A
// behavioural model predicts target, J/K pulses, latency, err and cout.
module tb_jk_bank_ctrl;
    localparam int W   = 4;
    localparam int MR0 = 1;
    localparam int MR1 = 2;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    jk_bank_ctrl_if #(.WIDTH(W)) bus0 ();
    jk_bank_ctrl_if #(.WIDTH(W)) bus1 ();

    logic [W-1:0] jo [2];
    logic [W-1:0] ko [2];
    logic         bsy [2];
    logic         dn [2];
    logic         er [2];
    logic         co [2];
    logic         rdy [2];
    logic [W-1:0] raw0, raw1;
    logic [W-1:0] s0 [2];
    logic [W-1:0] s1 [2];
    logic [W-1:0] view0, view1;

    assign view0  = (raw0 & ~s0[0]) | s1[0];
    assign view1  = (raw1 & ~s0[1]) | s1[1];
    assign rdy[0] = bus0.cmd_ready;
    assign rdy[1] = bus1.cmd_ready;

    jk_bank_ctrl #(.WIDTH(W), .USE_TOGGLE(0), .MAX_RETRY(MR0)) u_dut0 (
        .clk(clk), .clear(clear), .cmd(bus0), .q_in(view0),
        .j_out(jo[0]), .k_out(ko[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]), .cout(co[0])
    );

    jk_bank_ctrl #(.WIDTH(W), .USE_TOGGLE(1), .MAX_RETRY(MR1)) u_dut1 (
        .clk(clk), .clear(clear), .cmd(bus1), .q_in(view1),
        .j_out(jo[1]), .k_out(ko[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]), .cout(co[1])
    );

    // External flip-flop banks, cleared together with the controllers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            raw0 <= '0;
            raw1 <= '0;
        end else begin
            raw0 <= (jo[0] & ~raw0) | (~ko[0] & raw0);
            raw1 <= (jo[1] & ~raw1) | (~ko[1] & raw1);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] mr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] vw(input int d, input logic [W-1:0] r);
        return (r & ~s0[d]) | s1[d];
    endfunction

    // One JK flip-flop per bit: 00 hold, 10 set, 01 reset, 11 toggle.
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) begin
            case ({j[b], k[b]})
                2'b10:   r[b] = 1'b1;
                2'b01:   r[b] = 1'b0;
                2'b11:   r[b] = ~q[b];
                default: r[b] = q[b];
            endcase
        end
        return r;
    endfunction

    function automatic logic [W-1:0] target(input logic [2:0] op, input logic [W-1:0] q,
                                            input logic [W-1:0] data, input logic ser,
                                            output logic c);
        int qi;
        int m;
        int r;
        qi = int'(q);
        m  = 1 << W;
        c  = 1'b0;
        r  = qi;
        case (op)
            3'd1: r = int'(data);
            3'd2: begin c = (qi == m - 1); r = (qi + 1) % m; end
            3'd3: begin c = (qi == 0);     r = (qi + m - 1) % m; end
            3'd4: begin c = (qi >= m / 2); r = (qi * 2) % m + int'(ser); end
            3'd5: begin c = (qi % 2 == 1); r = qi / 2 + int'(ser) * (m / 2); end
            3'd6: r = 0;
            3'd7: r = m - 1;
            default: r = qi;
        endcase
        return W'(r);
    endfunction

    task automatic set_bus(input logic v, input logic [2:0] op, input logic [W-1:0] data,
                           input logic ser);
        bus0.cmd_valid = v; bus0.cmd_op = op; bus0.cmd_data = data; bus0.ser_in = ser;
        bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_data = data; bus1.ser_in = ser;
    endtask

    // Called just after a falling edge with both controllers idle. Offers one
    // command, then checks every following cycle until both are idle again.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data, input logic ser,
                          input logic hold);
        logic [W-1:0] ej [2][8];
        logic [W-1:0] ek [2][8];
        int           exp_done [2];
        logic         exp_err [2];
        logic         exp_cout [2];
        logic [W-1:0] c, t, jd, kd;
        int           drives, last, maxr;
        logic         keep;
        logic [W-1:0] exj, exk;
        for (int d = 0; d < 2; d++) begin
            maxr   = (d == 0) ? MR0 : MR1;
            c      = vw(d, mr[d]);
            t      = target(op, c, data, ser, exp_cout[d]);
            drives = 0;
            forever begin
                if (d == 1) begin jd = t ^ c; kd = t ^ c; end
                else        begin jd = t & ~c; kd = ~t & c; end
                ej[d][drives] = jd;
                ek[d][drives] = kd;
                mr[d] = jk_next(mr[d], jd, kd);
                drives++;
                c = vw(d, mr[d]);
                if (c == t || drives > maxr) break;
            end
            exp_err[d]  = (c != t);
            exp_done[d] = 1 + 2 * drives;
        end
        keep = hold && (exp_done[0] == exp_done[1]);
        last = ((exp_done[0] > exp_done[1]) ? exp_done[0] : exp_done[1]) + 1;
        set_bus(1'b1, op, data, ser);
        check("ready_at_offer0", 32'(rdy[0]), 1);
        check("ready_at_offer1", 32'(rdy[1]), 1);
        @(posedge clk);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n == 1)
                set_bus(keep, 3'($urandom_range(0, 7)), W'($urandom), 1'($urandom));
            for (int d = 0; d < 2; d++) begin
                exj = '0;
                exk = '0;
                if (n % 2 == 1 && n < exp_done[d]) begin
                    exj = ej[d][n / 2];
                    exk = ek[d][n / 2];
                end
                check($sformatf("j%0d_n%0d", d, n), 32'(jo[d]), 32'(exj));
                check($sformatf("k%0d_n%0d", d, n), 32'(ko[d]), 32'(exk));
                check($sformatf("done%0d_n%0d", d, n), 32'(dn[d]), 32'(n == exp_done[d]));
                check($sformatf("busy%0d_n%0d", d, n), 32'(bsy[d]), 32'(n <= exp_done[d]));
                check($sformatf("ready%0d_n%0d", d, n), 32'(rdy[d]), 32'(n > exp_done[d]));
                if (n >= exp_done[d]) begin
                    check($sformatf("err%0d_n%0d", d, n), 32'(er[d]), 32'(exp_err[d]));
                    check($sformatf("cout%0d_n%0d", d, n), 32'(co[d]), 32'(exp_cout[d]));
                end
            end
        end
        check("bank0", 32'(view0), 32'(vw(0, mr[0])));
        check("bank1", 32'(view1), 32'(vw(1, mr[1])));
    endtask

    // Asynchronous clear, either from idle or in the middle of a DRIVE cycle.
    task automatic clear_test(input logic mid_drive);
        if (mid_drive) begin
            set_bus(1'b1, 3'd1, 4'b0110, 1'b0);
            @(posedge clk);
            @(negedge clk);
            set_bus(1'b0, 3'd0, '0, 1'b0);
            check("pre_clear_busy", 32'(bsy[0]), 1);
        end
        #2 clear = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("clr_j%0d", d), 32'(jo[d]), 0);
            check($sformatf("clr_k%0d", d), 32'(ko[d]), 0);
            check($sformatf("clr_busy%0d", d), 32'(bsy[d]), 0);
            check($sformatf("clr_done%0d", d), 32'(dn[d]), 0);
            check($sformatf("clr_ready%0d", d), 32'(rdy[d]), 0);
            mr[d] = '0;
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("ready_after_clear0", 32'(rdy[0]), 1);
        check("ready_after_clear1", 32'(rdy[1]), 1);
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_clear0", 32'(dn[0]), 0);
            check("no_done_after_clear1", 32'(dn[1]), 0);
        end
    endtask

    initial begin
        clear = 1'b1;
        s0[0] = '0; s0[1] = '0; s1[0] = '0; s1[1] = '0;
        mr[0] = '0; mr[1] = '0;
        set_bus(1'b0, 3'd0, '0, 1'b0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready%0d", d), 32'(rdy[d]), 0);
            check($sformatf("rst_jk%0d", d), 32'({jo[d], ko[d]}), 0);
            check($sformatf("rst_status%0d", d), 32'({bsy[d], dn[d], er[d], co[d]}), 0);
        end
        clear = 1'b0;
        @(negedge clk);

        clear_test(1'b0);
        clear_test(1'b1);

        do_cmd(3'd1, 4'b1010, 1'b0, 1'b0);   // LOAD from zero
        do_cmd(3'd7, '0, 1'b0, 1'b0);        // SET
        do_cmd(3'd2, '0, 1'b0, 1'b0);        // INC wraps 1111 -> 0000
        do_cmd(3'd1, 4'b1001, 1'b0, 1'b0);
        do_cmd(3'd4, '0, 1'b1, 1'b0);        // SHL -> 0011, cout 1
        do_cmd(3'd5, '0, 1'b0, 1'b0);        // SHR -> 0001, cout 1

        s0[0] = 4'b0001;                     // bit0 stuck at 0 on the first bank
        do_cmd(3'd1, 4'b0001, 1'b0, 1'b0);   // two drives, err
        s0[0] = '0;

        do_cmd(3'd1, 4'b0000, 1'b0, 1'b0);
        do_cmd(3'd2, '0, 1'b0, 1'b1);        // back-to-back with valid held high
        do_cmd(3'd2, '0, 1'b0, 1'b1);
        do_cmd(3'd3, '0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s0[d] = W'($urandom) & W'($urandom);
                    s1[d] = W'($urandom) & W'($urandom) & ~s0[d];
                end else begin
                    s0[d] = '0;
                    s1[d] = '0;
                end
            end
            do_cmd(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom),
                   (i != 39) && ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
